// File: rtl/fighter_motion_ctrl_if.sv
// Signal bundle between one fighter's motion engine and its neighbours:
// keycodes and hit information come in, sprite position and stock status go out.
interface fighter_motion_ctrl_if;
  logic [31:0] keycode;
  logic        hit;
  logic [12:0] launch_dist;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic [9:0]  spr_w;
  logic [9:0]  spr_h;
  logic        on_ground;
  logic        invuln;
  logic        death;
  logic [2:0]  lives;
  logic        game_over;

  modport master (output keycode, hit, launch_dist,
                  input  pos_x, pos_y, spr_w, spr_h, on_ground, invuln, death, lives, game_over);
  modport slave  (input  keycode, hit, launch_dist,
                  output pos_x, pos_y, spr_w, spr_h, on_ground, invuln, death, lives, game_over);
endinterface

// File: rtl/fighter_motion_ctrl.sv
// Per-fighter motion engine, one step per video frame: walk, gravity, jumps,
// knockback, platform landing/drop-through and the stock/respawn sequence.
//   state       | meaning
//   S_ALIVE     | physics and input active, hits accepted
//   S_DEAD      | frozen at revive point for RESPAWN_FRAMES
//   S_INVULN    | physics active, hits ignored for INVULN_FRAMES
//   S_GAME_OVER | stocks exhausted, frozen until reset
module fighter_motion_ctrl #(
  parameter logic [7:0] KEY_LEFT  = 8'h50,
  parameter logic [7:0] KEY_RIGHT = 8'h4F,
  parameter logic [7:0] KEY_DOWN  = 8'h51,
  parameter logic [7:0] KEY_UP    = 8'h52,
  parameter int X_RESET = 150,
  parameter int Y_RESET = 230,
  parameter int X_REVIVE = 290,
  parameter int Y_REVIVE = 100,
  parameter int X_MIN = 0,
  parameter int X_MAX = 610,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 450,
  parameter int CENTER_X = 320,
  parameter int SPR_W = 60,
  parameter int SPR_H = 60,
  parameter int WALK_V = 3,
  parameter int JUMP_V = 8,
  parameter int MAX_FALL = 6,
  parameter int GRAV_DIV = 2,
  parameter int STAGE_L = 78,
  parameter int STAGE_R = 481,
  parameter int STAGE_TOP = 286,
  parameter int SOFT0_L = 126,
  parameter int SOFT0_R = 260,
  parameter int SOFT1_L = 310,
  parameter int SOFT1_R = 432,
  parameter int SOFT_TOP = 216,
  parameter int LAND_WIN = 8,
  parameter int STOCKS = 3,
  parameter int RESPAWN_FRAMES = 60,
  parameter int INVULN_FRAMES = 120
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  fighter_motion_ctrl_if.slave ctrl_if
);
  typedef enum logic [1:0] {S_ALIVE, S_DEAD, S_INVULN, S_GAME_OVER} state_t;

  localparam logic signed [7:0] WALK_S      = 8'(WALK_V);
  localparam logic signed [7:0] JUMP_S      = 8'(JUMP_V);
  localparam logic signed [7:0] MAX_FALL_S  = 8'(MAX_FALL);
  localparam logic [3:0]        GRAV_RELOAD = 4'(GRAV_DIV - 1);

  state_t            r_state, w_state_nxt;
  logic [9:0]        r_pos_x, r_pos_y, w_pos_x_nxt, w_pos_y_nxt;
  logic signed [7:0] r_vy, r_kb, w_vy_nxt, w_kb_nxt, w_step_x, w_kb_mag, w_kb_load;
  logic              r_jumps_left, w_jumps_left_nxt;
  logic              r_up_prev;
  logic [3:0]        r_grav_cnt, w_grav_cnt_nxt;
  logic [2:0]        r_lives, w_lives_nxt;
  logic [6:0]        r_timer, w_timer_nxt;
  logic              r_death, w_death_nxt;
  logic              r_on_ground, w_on_ground_nxt;
  logic [10:0]       w_px, w_feet, w_sum_x, w_sum_y;
  logic [9:0]        w_snap_y;
  logic              w_key_left, w_key_right, w_key_down, w_key_up, w_up_edge;
  logic              w_fall_ok, w_on_stage, w_soft_y, w_on_soft, w_drop, w_grounded, w_ko;
  logic              w_unused_bits;

  function automatic logic key_pressed(input logic [31:0] kc, input logic [7:0] k);
    return (kc[7:0] == k) || (kc[15:8] == k) || (kc[23:16] == k) || (kc[31:24] == k);
  endfunction

  assign w_key_left  = key_pressed(ctrl_if.keycode, KEY_LEFT);
  assign w_key_right = key_pressed(ctrl_if.keycode, KEY_RIGHT);
  assign w_key_down  = key_pressed(ctrl_if.keycode, KEY_DOWN);
  assign w_key_up    = key_pressed(ctrl_if.keycode, KEY_UP);
  assign w_up_edge   = w_key_up & ~r_up_prev;

  // Landing needs the feet inside a shallow window below the platform top while not rising.
  assign w_px       = {1'b0, r_pos_x};
  assign w_feet     = {1'b0, r_pos_y} + 11'(SPR_H);
  assign w_fall_ok  = ~r_vy[7];
  assign w_on_stage = w_fall_ok && (w_feet >= 11'(STAGE_TOP)) && (w_feet < 11'(STAGE_TOP + LAND_WIN))
                      && (w_px > 11'(STAGE_L)) && (w_px < 11'(STAGE_R - SPR_W));
  assign w_soft_y   = w_fall_ok && (w_feet >= 11'(SOFT_TOP)) && (w_feet < 11'(SOFT_TOP + LAND_WIN));
  assign w_on_soft  = w_soft_y && (((w_px > 11'(SOFT0_L)) && (w_px < 11'(SOFT0_R - SPR_W)))
                      || ((w_px > 11'(SOFT1_L)) && (w_px < 11'(SOFT1_R - SPR_W))));
  assign w_drop     = w_key_down && w_on_soft && !w_on_stage;
  assign w_grounded = (w_on_stage || w_on_soft) && !w_drop;
  assign w_snap_y   = w_on_stage ? 10'(STAGE_TOP - SPR_H) : 10'(SOFT_TOP - SPR_H);

  assign w_ko = (r_pos_x <= 10'(X_MIN)) || (r_pos_x >= 10'(X_MAX))
                || (r_pos_y <= 10'(Y_MIN)) || (r_pos_y >= 10'(Y_MAX));

  assign w_kb_mag  = {1'b0, ctrl_if.launch_dist[11:5]};
  assign w_kb_load = (r_pos_x >= 10'(CENTER_X)) ? w_kb_mag : -w_kb_mag;

  always_comb begin
    w_state_nxt      = r_state;
    w_pos_x_nxt      = r_pos_x;
    w_pos_y_nxt      = r_pos_y;
    w_vy_nxt         = r_vy;
    w_kb_nxt         = r_kb;
    w_jumps_left_nxt = r_jumps_left;
    w_grav_cnt_nxt   = r_grav_cnt;
    w_lives_nxt      = r_lives;
    w_timer_nxt      = r_timer;
    w_death_nxt      = 1'b0;
    w_on_ground_nxt  = 1'b0;
    w_step_x         = 8'sd0;
    w_sum_x          = 11'd0;
    w_sum_y          = 11'd0;
    unique case (r_state)
      S_ALIVE, S_INVULN: begin
        if (w_ko) begin
          w_death_nxt      = 1'b1;
          w_lives_nxt      = r_lives - 3'd1;
          w_pos_x_nxt      = 10'(X_REVIVE);
          w_pos_y_nxt      = 10'(Y_REVIVE);
          w_vy_nxt         = 8'sd0;
          w_kb_nxt         = 8'sd0;
          w_jumps_left_nxt = 1'b1;
          w_grav_cnt_nxt   = GRAV_RELOAD;
          w_timer_nxt      = 7'(RESPAWN_FRAMES - 1);
          w_state_nxt      = (r_lives == 3'd1) ? S_GAME_OVER : S_DEAD;
        end else begin
          if (w_grounded) begin
            w_vy_nxt         = 8'sd0;
            w_grav_cnt_nxt   = GRAV_RELOAD;
            w_jumps_left_nxt = 1'b1;
            w_on_ground_nxt  = !w_up_edge;
          end else if (w_drop) begin
            w_vy_nxt       = 8'sd1;
            w_grav_cnt_nxt = GRAV_RELOAD;
          end else if (r_grav_cnt == 4'd0) begin
            w_vy_nxt       = (r_vy >= MAX_FALL_S) ? MAX_FALL_S : r_vy + 8'sd1;
            w_grav_cnt_nxt = GRAV_RELOAD;
          end else begin
            w_grav_cnt_nxt = r_grav_cnt - 4'd1;
          end
          if (w_up_edge && (w_grounded || r_jumps_left)) begin
            w_vy_nxt       = -JUMP_S;
            w_grav_cnt_nxt = GRAV_RELOAD;
            if (!w_grounded) w_jumps_left_nxt = 1'b0;
          end
          if (r_kb != 8'sd0)    w_step_x = r_kb;
          else if (w_key_left)  w_step_x = -WALK_S;
          else if (w_key_right) w_step_x = WALK_S;
          if (ctrl_if.hit && (r_state == S_ALIVE)) w_kb_nxt = w_kb_load;
          else if (r_kb > 8'sd0)                   w_kb_nxt = r_kb - 8'sd1;
          else if (r_kb < 8'sd0)                   w_kb_nxt = r_kb + 8'sd1;
          w_sum_x     = {1'b0, r_pos_x} + {{3{w_step_x[7]}}, w_step_x};
          w_sum_y     = {1'b0, (w_grounded ? w_snap_y : r_pos_y)} + {{3{w_vy_nxt[7]}}, w_vy_nxt};
          w_pos_x_nxt = w_sum_x[9:0];
          w_pos_y_nxt = w_sum_y[9:0];
          if (r_state == S_INVULN) begin
            if (r_timer == 7'd0) w_state_nxt = S_ALIVE;
            else                 w_timer_nxt = r_timer - 7'd1;
          end
        end
      end
      S_DEAD: begin
        if (r_timer == 7'd0) begin
          w_state_nxt = S_INVULN;
          w_timer_nxt = 7'(INVULN_FRAMES - 1);
        end else begin
          w_timer_nxt = r_timer - 7'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_ALIVE;
      r_pos_x      <= 10'(X_RESET);
      r_pos_y      <= 10'(Y_RESET);
      r_vy         <= 8'sd0;
      r_kb         <= 8'sd0;
      r_jumps_left <= 1'b1;
      r_up_prev    <= 1'b0;
      r_grav_cnt   <= GRAV_RELOAD;
      r_lives      <= 3'(STOCKS);
      r_timer      <= 7'd0;
      r_death      <= 1'b0;
      r_on_ground  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pos_x      <= w_pos_x_nxt;
      r_pos_y      <= w_pos_y_nxt;
      r_vy         <= w_vy_nxt;
      r_kb         <= w_kb_nxt;
      r_jumps_left <= w_jumps_left_nxt;
      r_up_prev    <= w_key_up;
      r_grav_cnt   <= w_grav_cnt_nxt;
      r_lives      <= w_lives_nxt;
      r_timer      <= w_timer_nxt;
      r_death      <= w_death_nxt;
      r_on_ground  <= w_on_ground_nxt;
    end
  end

  assign ctrl_if.pos_x     = r_pos_x;
  assign ctrl_if.pos_y     = r_pos_y;
  assign ctrl_if.spr_w     = 10'(SPR_W);
  assign ctrl_if.spr_h     = 10'(SPR_H);
  assign ctrl_if.on_ground = r_on_ground;
  assign ctrl_if.invuln    = (r_state == S_INVULN);
  assign ctrl_if.death     = r_death;
  assign ctrl_if.lives     = r_lives;
  assign ctrl_if.game_over = (r_state == S_GAME_OVER);

  assign w_unused_bits = &{1'b0, ctrl_if.launch_dist[12], ctrl_if.launch_dist[4:0], w_sum_x[10], w_sum_y[10]};
endmodule
